// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the core pipeline and the stall/flush sequencer.
// Carries per-stage hazard sources from the pipeline (ID operands, EX op class, MEM handshake)
// and returns the per-register stall/flush controls, PC hold, MDU busy flag and stall counter.
//
// Modports:
//   master : pipeline side, drives hazard sources and consumes the controls
//   slave  : sequencer side, consumes hazard sources and drives the controls
interface pipe_hazard_ctrl_if;
    // ID stage operand usage
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;

    // EX stage instruction class
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_mdu_op;
    logic        ex_redirect;

    // MEM stage data-memory handshake
    logic        mem_req;
    logic        mem_ready;

    // Pipe-register controls
    logic        pc_stall;
    logic        stall_ifid;
    logic        stall_idex;
    logic        stall_exmem;
    logic        stall_memwb;
    logic        flush_ifid;
    logic        flush_idex;
    logic        flush_exmem;
    logic        flush_memwb;

    // Status
    logic        mdu_busy;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_mem_read, ex_rd, ex_mdu_op, ex_redirect,
        output mem_req, mem_ready,
        input  pc_stall,
        input  stall_ifid, stall_idex, stall_exmem, stall_memwb,
        input  flush_ifid, flush_idex, flush_exmem, flush_memwb,
        input  mdu_busy, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_mem_read, ex_rd, ex_mdu_op, ex_redirect,
        input  mem_req, mem_ready,
        output pc_stall,
        output stall_ifid, stall_idex, stall_exmem, stall_memwb,
        output flush_ifid, flush_idex, flush_exmem, flush_memwb,
        output mdu_busy, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves mem-wait, MDU occupancy,
// EX redirect and load-use hazards in that priority order.
// Latency: controls are combinational from state and inputs; stall counter updates next cycle.
// Backpressure: mem_wait freezes the whole pipe; MDU occupancy holds PC/IF/ID/EX and bubbles MEM.
//
// Ports:
//   clk  : core clock
//   rst  : synchronous active-high reset
//   hz   : hazard-control bundle (slave side)
module pipe_hazard_ctrl #(
    parameter int unsigned MDU_LATENCY = 4,   // cycles an MDU op occupies EX, 2..255
    parameter int unsigned CNT_W       = 8    // occupancy counter width
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       stall_cnt_q;

    // Hazard detection
    logic mem_wait;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;
    logic mdu_start;
    logic mdu_last;      // BUSY with counter at 1: the op's final EX cycle
    logic mdu_hold;

    // Combinational controls
    logic pc_stall_c;
    logic stall_ifid_c;
    logic stall_idex_c;
    logic stall_exmem_c;
    logic stall_memwb_c;
    logic flush_ifid_c;
    logic flush_idex_c;
    logic flush_exmem_c;
    logic flush_memwb_c;

    always_comb begin
        mem_wait  = hz.mem_req & ~hz.mem_ready;

        rs1_hit   = hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd);
        rs2_hit   = hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd);
        // x0 is hardwired zero, so a load targeting it never creates a dependency.
        load_use  = hz.ex_mem_read & (hz.ex_rd != 5'd0) & (rs1_hit | rs2_hit);

        // A new MDU op cannot be accepted while the memory stage is frozen;
        // it simply waits in EX until mem_wait drops.
        mdu_start = (state_q == IDLE) & hz.ex_mdu_op & ~mem_wait;
        mdu_last  = (state_q == BUSY) & (cnt_q == CNT_ONE);
        // The last BUSY cycle is not a hold: the op leaves EX at the end of it.
        mdu_hold  = mdu_start | ((state_q == BUSY) & (cnt_q > CNT_ONE));
    end

    // Priority resolution. Reset forces bubbles into every pipe register.
    always_comb begin
        pc_stall_c    = 1'b0;
        stall_ifid_c  = 1'b0;
        stall_idex_c  = 1'b0;
        stall_exmem_c = 1'b0;
        stall_memwb_c = 1'b0;
        flush_ifid_c  = 1'b0;
        flush_idex_c  = 1'b0;
        flush_exmem_c = 1'b0;
        flush_memwb_c = 1'b0;

        if (rst) begin
            flush_ifid_c  = 1'b1;
            flush_idex_c  = 1'b1;
            flush_exmem_c = 1'b1;
            flush_memwb_c = 1'b1;
        end else if (mem_wait) begin
            // Whole pipe frozen; a pending redirect is deferred until memory completes
            // so the branch stays in EX and is re-evaluated then.
            pc_stall_c    = 1'b1;
            stall_ifid_c  = 1'b1;
            stall_idex_c  = 1'b1;
            stall_exmem_c = 1'b1;
            stall_memwb_c = 1'b1;
        end else if (mdu_hold) begin
            // MDU op stays in EX; MEM gets a bubble and the older instruction drains to WB.
            // This also wins over a (illegal) simultaneous redirect.
            pc_stall_c    = 1'b1;
            stall_ifid_c  = 1'b1;
            stall_idex_c  = 1'b1;
            flush_exmem_c = 1'b1;
        end else if (hz.ex_redirect) begin
            // PC loads the target; the two younger instructions are wrong-path,
            // which is why this beats load_use.
            flush_ifid_c  = 1'b1;
            flush_idex_c  = 1'b1;
        end else if (load_use) begin
            pc_stall_c    = 1'b1;
            stall_ifid_c  = 1'b1;
            flush_idex_c  = 1'b1;
        end
    end

    // MDU occupancy FSM and stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mdu_start) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt_q > CNT_ONE) begin
                        // Counts down even under mem_wait: the MDU keeps computing.
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (mdu_last && !mem_wait) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                    // cnt==1 under mem_wait: hold, residency extends one cycle.
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase

            // Wraps naturally at 2^32.
            stall_cnt_q <= stall_cnt_q + {31'd0, pc_stall_c};
        end
    end

    assign hz.pc_stall     = pc_stall_c;
    assign hz.stall_ifid   = stall_ifid_c;
    assign hz.stall_idex   = stall_idex_c;
    assign hz.stall_exmem  = stall_exmem_c;
    assign hz.stall_memwb  = stall_memwb_c;
    assign hz.flush_ifid   = flush_ifid_c;
    assign hz.flush_idex   = flush_idex_c;
    assign hz.flush_exmem  = flush_exmem_c;
    assign hz.flush_memwb  = flush_memwb_c;
    assign hz.mdu_busy     = ~rst & (state_q == BUSY);
    assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MDU_LATENCY=4).
// Each step drives one cycle of inputs and queues the expected control vector;
// the vector is popped and compared mid-cycle, and the stall counter is tracked alongside.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(
        .MDU_LATENCY (4),
        .CNT_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector layout:
    // [9] pc_stall [8] stall_ifid [7] stall_idex [6] stall_exmem [5] stall_memwb
    // [4] flush_ifid [3] flush_idex [2] flush_exmem [1] flush_memwb [0] mdu_busy
    localparam logic [9:0] C_NONE  = 10'b0_0000_0000_0;
    localparam logic [9:0] C_RST   = 10'b0_0000_1111_0;
    localparam logic [9:0] C_LU    = 10'b1_1000_0100_0;
    localparam logic [9:0] C_MSTRT = 10'b1_1100_0010_0;
    localparam logic [9:0] C_MHOLD = 10'b1_1100_0010_1;
    localparam logic [9:0] C_MLAST = 10'b0_0000_0000_1;
    localparam logic [9:0] C_MW    = 10'b1_1111_0000_0;
    localparam logic [9:0] C_MWB   = 10'b1_1111_0000_1;
    localparam logic [9:0] C_RD    = 10'b0_0000_1100_0;

    int checks;
    int errors;
    logic [31:0] exp_cnt;
    logic [9:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ctl_vec();
        return {hz.pc_stall, hz.stall_ifid, hz.stall_idex, hz.stall_exmem, hz.stall_memwb,
                hz.flush_ifid, hz.flush_idex, hz.flush_exmem, hz.flush_memwb, hz.mdu_busy};
    endfunction

    // One cycle: drive, queue expectation, compare at negedge, then advance past posedge.
    task automatic step(input string tag, input logic r,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic mr, input logic [4:0] rd,
                        input logic mdu, input logic redir,
                        input logic mreq, input logic mrdy,
                        input logic [9:0] exp);
        logic [9:0] e;
        rst            = r;
        hz.id_rs1      = rs1;
        hz.id_rs1_used = u1;
        hz.id_rs2      = rs2;
        hz.id_rs2_used = u2;
        hz.ex_mem_read = mr;
        hz.ex_rd       = rd;
        hz.ex_mdu_op   = mdu;
        hz.ex_redirect = redir;
        hz.mem_req     = mreq;
        hz.mem_ready   = mrdy;
        exp_q.push_back(exp);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_ctl"}, {22'd0, ctl_vec()}, {22'd0, e});
            chk({tag, "_cnt"}, hz.stall_cycles, exp_cnt);
        end
        @(posedge clk);
        if (r) exp_cnt = 32'd0;
        else   exp_cnt = exp_cnt + {31'd0, exp[9]};
        #1;
    endtask

    // Shorthands for common input shapes.
    task automatic idle(input string tag, input logic [9:0] exp);
        step(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic mdu(input string tag, input logic mreq, input logic mrdy, input logic [9:0] exp);
        step(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, mreq, mrdy, exp);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 32'd0;

        rst            = 1'b1;
        hz.id_rs1      = '0;
        hz.id_rs2      = '0;
        hz.id_rs1_used = 1'b0;
        hz.id_rs2_used = 1'b0;
        hz.ex_mem_read = 1'b0;
        hz.ex_rd       = '0;
        hz.ex_mdu_op   = 1'b0;
        hz.ex_redirect = 1'b0;
        hz.mem_req     = 1'b0;
        hz.mem_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        step("rst0", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RST);
        idle("idle0", C_NONE);

        // Load-use on rs2, then the load has moved to MEM
        step("lu_rs2", 1'b0, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_LU);
        idle("lu_after", C_NONE);
        // Load to x0 never stalls
        step("lu_x0", 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);
        // rs1 match used / unused
        step("lu_rs1", 1'b0, 5'd7, 1'b1, 5'd2, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_LU);
        step("lu_unused", 1'b0, 5'd7, 1'b0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);

        // Plain MDU op, latency 4: 3 held cycles then the completing cycle
        mdu("mdu_s", 1'b0, 1'b0, C_MSTRT);
        mdu("mdu_h1", 1'b0, 1'b0, C_MHOLD);
        mdu("mdu_h2", 1'b0, 1'b0, C_MHOLD);
        mdu("mdu_last", 1'b0, 1'b0, C_MLAST);
        idle("mdu_done", C_NONE);

        // MDU arrives during mem_wait: memory freeze wins, no start yet
        mdu("mdu_mw_pre", 1'b1, 1'b0, C_MW);
        mdu("mdumw_s", 1'b1, 1'b1, C_MSTRT);
        mdu("mdumw_h1", 1'b0, 1'b0, C_MHOLD);
        mdu("mdumw_h2", 1'b0, 1'b0, C_MHOLD);
        // cnt==1 with mem_wait for two cycles extends residency to 6
        mdu("mdumw_w1", 1'b1, 1'b0, C_MWB);
        mdu("mdumw_w2", 1'b1, 1'b0, C_MWB);
        mdu("mdumw_last", 1'b1, 1'b1, C_MLAST);
        idle("mdumw_done", C_NONE);

        // Back-to-back MDU ops; the first also carries an illegal redirect (MDU wins)
        step("b2b_s1", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_MSTRT);
        mdu("b2b_h1", 1'b0, 1'b0, C_MHOLD);
        mdu("b2b_h2", 1'b0, 1'b0, C_MHOLD);
        mdu("b2b_l1", 1'b0, 1'b0, C_MLAST);
        mdu("b2b_s2", 1'b0, 1'b0, C_MSTRT);
        mdu("b2b_h3", 1'b0, 1'b0, C_MHOLD);
        mdu("b2b_h4", 1'b0, 1'b0, C_MHOLD);
        mdu("b2b_l2", 1'b0, 1'b0, C_MLAST);
        idle("b2b_done", C_NONE);

        // Redirect beats load-use in the same cycle
        step("rd_lu", 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, C_RD);

        // Redirect held under 3 mem_wait cycles: freeze only, flush when memory completes
        step("rd_mw1", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_MW);
        step("rd_mw2", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_MW);
        step("rd_mw3", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_MW);
        step("rd_mwgo", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_RD);
        idle("rd_done", C_NONE);

        // Reset mid-BUSY at cnt==2, held for 2 cycles
        mdu("rb_s", 1'b0, 1'b0, C_MSTRT);
        mdu("rb_h1", 1'b0, 1'b0, C_MHOLD);
        step("rb_rst1", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_RST);
        step("rb_rst2", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_RST);
        idle("rb_idle", C_NONE);
        idle("rb_idle2", C_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
